// File: rtl/cpu_mul_writeback_pkg.sv
// cpu_mul_writeback_pkg: shared types and sizing for the multiply writeback path
// Contents: writeback_mul_t (mul tail / FIFO entry), sb_cnt_w() scoreboard counter width, SB_CNT_W default.
// Defaults for MUL_STAGES, REG_WIDTH and NUM_REGS apply only when CPU_define.vh has not provided them.
`ifndef MUL_STAGES
`define MUL_STAGES 3
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
`ifndef NUM_REGS
`define NUM_REGS 32
`endif
package CPU_mul_pkg;
    typedef struct packed {
        logic                         writeback_mul;
        logic [$clog2(`NUM_REGS)-1:0] rd_id;
        logic [`REG_WIDTH-1:0]        mul_result;
    } writeback_mul_t;
    function automatic int sb_cnt_w(input int mul_stages, input int fifo_depth);
        return $clog2(mul_stages + fifo_depth + 1);
    endfunction
    localparam int SB_CNT_W = sb_cnt_w(`MUL_STAGES, 4);
endpackage

// File: rtl/cpu_mul_writeback_fifo.sv
// cpu_mul_result_fifo: synchronous result buffer for multiply results awaiting a free RF port
// Ports: clk, reset (sync, active-high); push/din enqueue; pop dequeues head; count/full/empty status.
// A pop frees its slot in the same cycle, so push+pop is accepted even when full.
module cpu_mul_result_fifo
    import CPU_mul_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  writeback_mul_t               din,
    output writeback_mul_t               head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    writeback_mul_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = 32'(count) == DEPTH;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
            if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
        end
    end
endmodule

// File: rtl/cpu_mul_writeback.sv
// cpu_mul_writeback: merges multiply-pipeline results with main writeback onto the single RF write port
// Ports: clk, reset (sync, active-high); issue_* from decode; mul_tail_* from the last mul stage;
//   wb_* main writeback (always wins the port); rf_* registered RF write port;
//   mul_pending per-register outstanding-multiply flags; mul_issue_stall back to decode.
// Build option CPU_MUL_WB_FWD_EN: an uncontended tail result bypasses an empty FIFO straight onto rf_*.
module cpu_mul_writeback
    import CPU_mul_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MUL_STAGES = `MUL_STAGES,
    parameter int RW         = `REG_WIDTH,
    parameter int RID        = $clog2(`NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [RID-1:0]       issue_rd_id,
    input  logic                 mul_tail_valid,
    input  logic [RID-1:0]       mul_tail_rd_id,
    input  logic [RW-1:0]        mul_tail_result,
    input  logic                 wb_valid,
    input  logic [RID-1:0]       wb_rd_id,
    input  logic [RW-1:0]        wb_data,
    output logic                 rf_we,
    output logic [RID-1:0]       rf_waddr,
    output logic [RW-1:0]        rf_wdata,
    output logic [`NUM_REGS-1:0] mul_pending,
    output logic                 mul_issue_stall
);
    localparam int NR  = `NUM_REGS;
    localparam int SBW = sb_cnt_w(MUL_STAGES, FIFO_DEPTH);
    localparam int IFW = $clog2(MUL_STAGES + 1);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    writeback_mul_t tail, head;
    logic [CW-1:0] fifo_count;
    logic [IFW-1:0] inflight;
    logic fifo_full, fifo_empty, push, pop, bypass, mul_wr, rf_mul;
    logic [RID-1:0] mul_wr_rd;
    logic [RW-1:0] mul_wr_data;
    logic [NR-1:0] sb_inc, sb_dec;
`ifdef CPU_MUL_WB_FWD_EN
    assign bypass = !wb_valid && fifo_empty && mul_tail_valid;
`else
    assign bypass = 1'b0;
`endif
    always_comb begin
        tail            = {mul_tail_valid, mul_tail_rd_id, mul_tail_result};
        pop             = !wb_valid && !fifo_empty;
        push            = mul_tail_valid && !bypass;
        mul_wr          = pop || bypass;
        mul_wr_rd       = pop ? head.rd_id : mul_tail_rd_id;
        mul_wr_data     = pop ? head.mul_result : mul_tail_result;
        // counting in-flight results against FIFO space guarantees every tail finds a slot
        mul_issue_stall = (32'(fifo_count) + 32'(inflight)) >= FIFO_DEPTH;
        sb_inc          = issue_valid ? NR'(1) << issue_rd_id : '0;
        // retire when the mul result sits on rf_*, i.e. at the edge the RF captures it
        sb_dec          = (rf_we && rf_mul) ? NR'(1) << rf_waddr : '0;
    end
    cpu_mul_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (tail),
        .head  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_mul   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            inflight <= '0;
        end else begin
            rf_we    <= wb_valid || mul_wr;
            rf_mul   <= mul_wr;
            rf_waddr <= wb_valid ? wb_rd_id : mul_wr_rd;
            rf_wdata <= wb_valid ? wb_data : mul_wr_data;
            if (issue_valid != mul_tail_valid) inflight <= issue_valid ? inflight + 1'b1 : inflight - 1'b1;
        end
    end
    for (genvar g = 0; g < NR; g++) begin : g_sb
        logic [SBW-1:0] cnt;
        always_ff @(posedge clk) begin
            if (reset) cnt <= '0;
            else if (sb_inc[g] != sb_dec[g]) cnt <= sb_inc[g] ? cnt + 1'b1 : cnt - 1'b1;
            if (!reset) assert (!(sb_dec[g] && !sb_inc[g] && cnt == '0)) else $error("scoreboard underflow r%0d", g);
        end
        assign mul_pending[g] = cnt != '0;
    end
    always_ff @(posedge clk)
        if (!reset) begin
            assert (!(push && fifo_full && !pop)) else $error("mul result fifo overflow");
            assert (!(issue_valid && !mul_tail_valid && 32'(inflight) == MUL_STAGES)) else $error("inflight overflow");
            assert (!(mul_tail_valid && !issue_valid && inflight == '0)) else $error("inflight underflow");
            assert (!(issue_valid && mul_issue_stall)) else $error("multiply issued while stalled");
        end
endmodule

// File: tb/tb_cpu_mul_writeback.sv
// tb_cpu_mul_writeback: directed self-checking bench for cpu_mul_writeback
module tb_cpu_mul_writeback;
    import CPU_mul_pkg::*;
    localparam int RID = $clog2(`NUM_REGS);
    localparam int MS  = `MUL_STAGES;
`ifdef CPU_MUL_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset;
    logic issue_valid, mul_tail_valid, wb_valid;
    logic [RID-1:0] issue_rd_id, mul_tail_rd_id, wb_rd_id;
    logic [`REG_WIDTH-1:0] mul_tail_result, wb_data;
    logic rf_we, mul_issue_stall;
    logic [RID-1:0] rf_waddr;
    logic [`REG_WIDTH-1:0] rf_wdata;
    logic [`NUM_REGS-1:0] mul_pending;
    int n_checks = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    cpu_mul_writeback dut (
        .clk             (clk),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_rd_id     (issue_rd_id),
        .mul_tail_valid  (mul_tail_valid),
        .mul_tail_rd_id  (mul_tail_rd_id),
        .mul_tail_result (mul_tail_result),
        .wb_valid        (wb_valid),
        .wb_rd_id        (wb_rd_id),
        .wb_data         (wb_data),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .mul_pending     (mul_pending),
        .mul_issue_stall (mul_issue_stall)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        issue_valid = 0; issue_rd_id = '0;
        mul_tail_valid = 0; mul_tail_rd_id = '0; mul_tail_result = '0;
        wb_valid = 0; wb_rd_id = '0; wb_data = '0;
    endtask
    task automatic issue(input int rd);
        issue_valid = 1; issue_rd_id = RID'(rd);
        tick();
        issue_valid = 0;
    endtask
    task automatic mul_return(input int rd, input logic [31:0] data);
        mul_tail_valid = 1; mul_tail_rd_id = RID'(rd); mul_tail_result = `REG_WIDTH'(data);
        tick();
        mul_tail_valid = 0;
        if (!FWD) tick();
        check("mul_we", 64'(rf_we), 64'(1));
        check("mul_addr", 64'(rf_waddr), 64'(rd));
        check("mul_data", 64'(rf_wdata), 64'(data));
    endtask
    int seq_issue [6] = '{10, 11, 12, 13, -1, -1};
    int seq_tail  [6] = '{-1, -1, 10, 11, 12, 13};
    bit seq_stall [6] = '{0, 0, 0, 0, 1, 1};
    initial begin
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        check("rst_we", 64'(rf_we), 64'(0));
        check("rst_addr", 64'(rf_waddr), 64'(0));
        check("rst_data", 64'(rf_wdata), 64'(0));
        check("rst_pending", 64'(mul_pending), 64'(0));
        check("rst_stall", 64'(mul_issue_stall), 64'(0));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_we", 64'(rf_we), 64'(0));
            check("idle_pending", 64'(mul_pending), 64'(0));
            check("idle_stall", 64'(mul_issue_stall), 64'(0));
        end
        // single multiply to r5
        issue(5);
        check("r5_pending_issue", 64'(mul_pending[5]), 64'(1));
        for (int i = 1; i < MS; i++) tick();
        mul_return(5, 32'h0000_002A);
        check("r5_pending_at_write", 64'(mul_pending[5]), 64'(1));
        tick();
        check("r5_we_after", 64'(rf_we), 64'(0));
        check("r5_pending_clear", 64'(mul_pending[5]), 64'(0));
        // mul tail to r3 collides with three main writebacks to r7
        issue(3);
        mul_tail_valid = 1; mul_tail_rd_id = 3; mul_tail_result = 32'h33;
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1; wb_rd_id = 7; wb_data = 32'h70 + i;
            tick();
            mul_tail_valid = 0;
            check("conf_wb_we", 64'(rf_we), 64'(1));
            check("conf_wb_addr", 64'(rf_waddr), 64'(7));
            check("conf_wb_data", 64'(rf_wdata), 64'(32'h70 + i));
        end
        idle();
        tick();
        check("conf_mul_addr", 64'(rf_waddr), 64'(3));
        check("conf_mul_data", 64'(rf_wdata), 64'(32'h33));
        check("conf_mul_we", 64'(rf_we), 64'(1));
        tick();
        check("conf_fifo_empty", 64'(dut.fifo_count), 64'(0));
        check("conf_idle_we", 64'(rf_we), 64'(0));
        check("conf_pending", 64'(mul_pending), 64'(0));
        // fill the FIFO behind a held main writeback until stall
        for (int c = 0; c < 6; c++) begin
            check("fill_stall", 64'(mul_issue_stall), 64'(seq_stall[c]));
            wb_valid = 1; wb_rd_id = 1; wb_data = 32'h100 + c;
            issue_valid = seq_issue[c] >= 0; issue_rd_id = RID'(seq_issue[c] < 0 ? 0 : seq_issue[c]);
            mul_tail_valid = seq_tail[c] >= 0; mul_tail_rd_id = RID'(seq_tail[c] < 0 ? 0 : seq_tail[c]);
            mul_tail_result = 32'hA0 + c - 2;
            tick();
            check("fill_wb_addr", 64'(rf_waddr), 64'(1));
            check("fill_wb_data", 64'(rf_wdata), 64'(32'h100 + c));
        end
        idle();
        check("full_stall", 64'(mul_issue_stall), 64'(1));
        check("full_count", 64'(dut.fifo_count), 64'(4));
        for (int k = 0; k < 4; k++) begin
            tick();
            check("drain_we", 64'(rf_we), 64'(1));
            check("drain_addr", 64'(rf_waddr), 64'(10 + k));
            check("drain_data", 64'(rf_wdata), 64'(32'hA0 + k));
            check("drain_stall", 64'(mul_issue_stall), 64'(0));
        end
        tick();
        check("drain_done_we", 64'(rf_we), 64'(0));
        tick();
        check("drain_pending", 64'(mul_pending), 64'(0));
        // two back-to-back muls to r9, then a same-cycle issue and retire of r9
        issue(9);
        issue(9);
        mul_return(9, 32'h91);
        check("r9_pending_a", 64'(mul_pending[9]), 64'(1));
        issue(9);
        check("r9_pending_b", 64'(mul_pending[9]), 64'(1));
        mul_return(9, 32'h92);
        check("r9_pending_c", 64'(mul_pending[9]), 64'(1));
        mul_return(9, 32'h93);
        check("r9_pending_d", 64'(mul_pending[9]), 64'(1));
        tick();
        check("r9_pending_clear", 64'(mul_pending[9]), 64'(0));
        // reset with two results buffered
        issue(20);
        issue(21);
        for (int i = 0; i < 2; i++) begin
            wb_valid = 1; wb_rd_id = 1; wb_data = 32'h200 + i;
            mul_tail_valid = 1; mul_tail_rd_id = RID'(20 + i); mul_tail_result = 32'hB0 + i;
            tick();
        end
        idle();
        check("pre_rst_count", 64'(dut.fifo_count), 64'(2));
        reset = 1;
        tick();
        reset = 0;
        check("mid_rst_we", 64'(rf_we), 64'(0));
        check("mid_rst_addr", 64'(rf_waddr), 64'(0));
        check("mid_rst_count", 64'(dut.fifo_count), 64'(0));
        check("mid_rst_pending", 64'(mul_pending), 64'(0));
        check("mid_rst_stall", 64'(mul_issue_stall), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_we", 64'(rf_we), 64'(0));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
